minisys_io_responder: RTL and testbench
=======================================

// Module: minisys_io_responder
// PURPOSE
//  Peripheral-side end of the CPU port-I/O path. Responds to IORead/IOWrite strobes for the
//  0xFFFFFC00 I/O window, using the low 10 address bits. Owns the LED output registers,
//  the synchronised switch inputs and a 16-bit prescaled down-timer. Returns read data to
//  the memory/IO write-back mux in the same cycle as the access.
// PARAMETERS
//  DATA_W     16    I/O data width; all registers are DATA_W or narrower
//  PRESCALE   1000  timer tick every PRESCALE clocks (>=1); prescaler width = $clog2(PRESCALE)
//  SYNC_STAGES 2    flip-flop stages on switch_in (>=2)
// PORTS
//  clock       in   1       system clock; every register is on its rising edge
//  reset       in   1       synchronous, active-high
//  IORead      in   1       read strobe from control decode, one cycle per access
//  IOWrite     in   1       write strobe from control decode, one cycle per access
//  io_addr     in   10      Alu_Result[9:0], byte offset inside the I/O window
//  io_wdata    in   DATA_W  store data (rt[15:0])
//  io_rdata    out  DATA_W  read data, combinational, valid while IORead=1, else 0
//  io_err      out  1       registered 1-cycle pulse on an access to an unmapped offset
//  switch_in   in   24      asynchronous board switches
//  led_out     out  24      LED drive, {LEDHI[7:0], LEDLO[15:0]}
//  timer_irq   out  1       level output, equal to the sticky DONE flag
// BEHAVIOUR
//  Register map (offsets; other offsets are unmapped):
//   0x060 LEDLO RW [15:0]; 0x062 LEDHI RW [7:0], read returns zero-extended
//   0x070 SWLO RO = sync switch[15:0]; 0x072 SWHI RO = {8'b0, sync switch[23:16]}
//   0x020 CTRL W: bit0 EN, bit1 RELOAD. Read returns STATUS {13'b0, RELOAD, EN, DONE}
//   0x024 LOAD W [15:0]. Read returns the current COUNT
//  Writes commit on the clock edge where IOWrite=1. Writes to RO offsets are ignored with no error.
//  Reads have no latency. Side effects of a read (clearing DONE) commit on the edge that ends the read.
//  IORead and IOWrite both asserted: treated as a write. io_rdata=0. No error.
//  Unmapped offset with either strobe: no state change, io_rdata=0, io_err=1 in the next cycle.
//  Switch path: SYNC_STAGES flops. A switch change is visible on SW* reads SYNC_STAGES cycles later.
//  Timer:
//   - Writing LOAD sets LOAD and also sets COUNT=LOAD. The prescaler is cleared.
//   - Writing CTRL sets EN and RELOAD and clears the prescaler. DONE is unchanged.
//   - While EN=1 the prescaler counts 0..PRESCALE-1. At wrap there is one tick.
//   - A tick with COUNT>1 decrements COUNT.
//   - A tick with COUNT==1 sets COUNT=0 and DONE=1. Then:
//       RELOAD=1: COUNT=LOAD, EN stays 1
//       RELOAD=0: EN=0
//   - EN=1 with COUNT==0 produces no ticks and does not set DONE.
//   - A read of STATUS clears DONE, but a DONE-set on the same edge wins (DONE stays 1).
//     The read itself returns the pre-edge value.
//   - A CTRL write on the expiry edge: the written EN/RELOAD win, and DONE is still set.
//   - A LOAD write on a tick edge: the written value wins and the decrement is discarded.
//  Reset values:
//   - LEDLO, LEDHI, led_out = 0
//   - switch sync flops = 0
//   - EN, RELOAD, DONE, timer_irq = 0; LOAD, COUNT, prescaler = 0
//   - io_err = 0
//   - io_rdata = 0, because the strobes are 0
//  Reset asserted mid-count: everything returns to reset values on the next edge. Any strobe in
//  that cycle is ignored.
// STRUCTURE
//  Package minisys_io_pkg:
//   - offset localparams IO_LEDLO, IO_LEDHI, IO_SWLO, IO_SWHI, IO_TCTRL, IO_TLOAD
//   - STATUS bit indices
//   - IO_WINDOW_HI = 22'h3FFFFF, shared with the control decoder
//  One sub-module, minisys_io_timer:
//   - contains prescaler, COUNT, LOAD, EN, RELOAD, DONE
//   - inputs: ctrl_we, load_we, wdata, status_rd
//   - outputs: count, status
//  The top level holds address decode, the LED registers, the switch synchroniser and the read mux.
// TESTING (bench uses PRESCALE=4)
//  1 Reset, then IOWrite 0x060=0xA5A5 and 0x062=0x01FF -> led_out=24'hFFA5A5; read 0x062 returns 0x00FF.
//  2 switch_in=24'h123456 -> read 0x070=0x3456 and 0x072=0x0012 from cycle SYNC_STAGES on, not before.
//  3 LOAD=3, CTRL=0x1 -> COUNT 3,2,1,0 at 4-cycle spacing; DONE=1 and timer_irq=1 at the 12th edge;
//    EN=0; read 0x020 returns 0x0001, and DONE=0 after that edge.
//  4 LOAD=2, CTRL=0x3 -> DONE at the 8th edge and COUNT reloads to 2. A STATUS read on the 16th
//    edge (second expiry) leaves DONE=1.
//  5 Read 0x040 and write 0x3FE -> io_rdata=0 and io_err pulses 1 cycle each. No register changes.
//  6 Mid-count (COUNT=2, EN=1, LED=0xFFFF) assert reset 1 cycle -> all outputs and registers 0.
//    An IOWrite in the reset cycle has no effect.

Source files
------------

// File: rtl/minisys_io_pkg.sv
// Shared constants for the port-I/O window: register offsets, STATUS bit positions
// and the upper-address match used by the control decoder.
package minisys_io_pkg;

  localparam logic [21:0] IO_WINDOW_HI = 22'h3FFFFF;

  localparam logic [9:0] IO_TCTRL = 10'h020;
  localparam logic [9:0] IO_TLOAD = 10'h024;
  localparam logic [9:0] IO_LEDLO = 10'h060;
  localparam logic [9:0] IO_LEDHI = 10'h062;
  localparam logic [9:0] IO_SWLO  = 10'h070;
  localparam logic [9:0] IO_SWHI  = 10'h072;

  localparam int unsigned ST_DONE   = 0;
  localparam int unsigned ST_EN     = 1;
  localparam int unsigned ST_RELOAD = 2;

  function automatic logic io_mapped(input logic [9:0] addr);
    case (addr)
      IO_TCTRL, IO_TLOAD, IO_LEDLO, IO_LEDHI, IO_SWLO, IO_SWHI: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/minisys_io_timer.sv
// Prescaled 16-bit down-timer with one-shot/reload modes and a sticky DONE flag.
module minisys_io_timer
  import minisys_io_pkg::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned PRESCALE = 1000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ctrl_we,
  input  logic              load_we,
  input  logic [DATA_W-1:0] wdata,
  input  logic              status_rd,
  output logic [DATA_W-1:0] count,
  output logic [DATA_W-1:0] status
);

  localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0]   presc;
  logic [DATA_W-1:0] load;
  logic              en;
  logic              reload;
  logic              done;
  logic              tick;
  logic              expire;

  always_comb begin
    tick   = en && (presc == PS_MAX) && (count != '0);
    expire = tick && (count == DATA_W'(1));
    status = '0;
    status[ST_DONE]   = done;
    status[ST_EN]     = en;
    status[ST_RELOAD] = reload;
  end

  // Register writes are applied last so they override tick effects on the same edge;
  // DONE is not touched by writes, so an expiry still sets it.
  always_ff @(posedge clock) begin
    if (reset) begin
      presc  <= '0;
      load   <= '0;
      count  <= '0;
      en     <= 1'b0;
      reload <= 1'b0;
      done   <= 1'b0;
    end else begin
      if (en) presc <= (presc == PS_MAX) ? '0 : presc + 1'b1;
      if (tick) count <= expire ? (reload ? load : '0) : count - 1'b1;
      if (expire && !reload) en <= 1'b0;
      if (expire) done <= 1'b1;
      else if (status_rd) done <= 1'b0;
      if (ctrl_we) begin
        en     <= wdata[0];
        reload <= wdata[1];
        presc  <= '0;
      end
      if (load_we) begin
        load  <= wdata;
        count <= wdata;
        presc <= '0;
      end
    end
  end

endmodule

// File: rtl/minisys_io_responder.sv
// Peripheral side of the CPU port-I/O path: address decode, LED registers,
// switch synchroniser, timer and the zero-latency read mux.
module minisys_io_responder
  import minisys_io_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned PRESCALE    = 1000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              IORead,
  input  logic              IOWrite,
  input  logic [9:0]        io_addr,
  input  logic [DATA_W-1:0] io_wdata,
  output logic [DATA_W-1:0] io_rdata,
  output logic              io_err,
  input  logic [23:0]       switch_in,
  output logic [23:0]       led_out,
  output logic              timer_irq
);

  logic [15:0]       ledlo;
  logic [7:0]        ledhi;
  logic [23:0]       sync_q [SYNC_STAGES];
  logic [23:0]       sw_sync;
  logic              wr;
  logic              rd;
  logic [DATA_W-1:0] t_count;
  logic [DATA_W-1:0] t_status;

  // A simultaneous read+write is handled purely as a write.
  always_comb begin
    wr      = IOWrite;
    rd      = IORead && !IOWrite;
    sw_sync = sync_q[SYNC_STAGES-1];
    led_out = {ledhi, ledlo};
    timer_irq = t_status[ST_DONE];
  end

  minisys_io_timer #(
    .DATA_W  (DATA_W),
    .PRESCALE(PRESCALE)
  ) u_timer (
    .clock    (clock),
    .reset    (reset),
    .ctrl_we  (wr && (io_addr == IO_TCTRL)),
    .load_we  (wr && (io_addr == IO_TLOAD)),
    .wdata    (io_wdata),
    .status_rd(rd && (io_addr == IO_TCTRL)),
    .count    (t_count),
    .status   (t_status)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      ledlo  <= '0;
      ledhi  <= '0;
      io_err <= 1'b0;
    end else begin
      if (wr && (io_addr == IO_LEDLO)) ledlo <= io_wdata[15:0];
      if (wr && (io_addr == IO_LEDHI)) ledhi <= io_wdata[7:0];
      io_err <= (IORead || IOWrite) && !io_mapped(io_addr);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= switch_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  always_comb begin
    io_rdata = '0;
    if (rd) begin
      case (io_addr)
        IO_LEDLO: io_rdata = DATA_W'(ledlo);
        IO_LEDHI: io_rdata = DATA_W'(ledhi);
        IO_SWLO:  io_rdata = DATA_W'(sw_sync[15:0]);
        IO_SWHI:  io_rdata = DATA_W'(sw_sync[23:16]);
        IO_TCTRL: io_rdata = t_status;
        IO_TLOAD: io_rdata = t_count;
        default:  io_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_minisys_io_responder.sv
// Self-checking bench for minisys_io_responder: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model of the register map.
module tb_minisys_io_responder;

  localparam int PRE  = 4;
  localparam int SYNC = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        IORead = 1'b0;
  logic        IOWrite = 1'b0;
  logic [9:0]  io_addr = '0;
  logic [15:0] io_wdata = '0;
  logic [15:0] io_rdata;
  logic        io_err;
  logic [23:0] switch_in = '0;
  logic [23:0] led_out;
  logic        timer_irq;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int          m_ledlo, m_ledhi, m_load, m_count, m_ps;
  bit          m_en, m_reload, m_done, m_err;
  logic [23:0] m_sw [SYNC];

  minisys_io_responder #(
    .DATA_W     (16),
    .PRESCALE   (PRE),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .IORead   (IORead),
    .IOWrite  (IOWrite),
    .io_addr  (io_addr),
    .io_wdata (io_wdata),
    .io_rdata (io_rdata),
    .io_err   (io_err),
    .switch_in(switch_in),
    .led_out  (led_out),
    .timer_irq(timer_irq)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic bit is_mapped(input logic [9:0] a);
    return a == 10'h060 || a == 10'h062 || a == 10'h070 || a == 10'h072 ||
           a == 10'h020 || a == 10'h024;
  endfunction

  function automatic logic [15:0] exp_rdata();
    if (!IORead || IOWrite) return 16'h0;
    case (io_addr)
      10'h060: return 16'(m_ledlo);
      10'h062: return 16'(m_ledhi);
      10'h070: return m_sw[SYNC-1][15:0];
      10'h072: return {8'h00, m_sw[SYNC-1][23:16]};
      10'h020: return {13'h0, m_reload, m_en, m_done};
      10'h024: return 16'(m_count);
      default: return 16'h0;
    endcase
  endfunction

  function automatic void model_edge();
    bit wr, rd, tick, expired;
    if (reset) begin
      m_ledlo = 0; m_ledhi = 0; m_load = 0; m_count = 0; m_ps = 0;
      m_en = 0; m_reload = 0; m_done = 0; m_err = 0;
      for (int i = 0; i < SYNC; i++) m_sw[i] = '0;
      return;
    end
    wr = IOWrite;
    rd = IORead && !IOWrite;
    for (int i = SYNC - 1; i > 0; i--) m_sw[i] = m_sw[i-1];
    m_sw[0] = switch_in;
    m_err = (IORead || IOWrite) && !is_mapped(io_addr);
    tick = m_en && m_count > 0 && m_ps == PRE - 1;
    if (m_en) m_ps = (m_ps + 1) % PRE;
    expired = 0;
    if (tick) begin
      if (m_count == 1) begin
        expired = 1;
        m_count = m_reload ? m_load : 0;
        if (!m_reload) m_en = 0;
      end else begin
        m_count = m_count - 1;
      end
    end
    if (expired) m_done = 1;
    else if (rd && io_addr == 10'h020) m_done = 0;
    if (wr) begin
      case (io_addr)
        10'h060: m_ledlo = int'(io_wdata);
        10'h062: m_ledhi = int'(io_wdata[7:0]);
        10'h020: begin m_en = io_wdata[0]; m_reload = io_wdata[1]; m_ps = 0; end
        10'h024: begin m_load = int'(io_wdata); m_count = m_load; m_ps = 0; end
        default: ;
      endcase
    end
  endfunction

  task automatic cyc();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic bus(input bit rd, input bit wr, input logic [9:0] a, input logic [15:0] d);
    IORead = rd; IOWrite = wr; io_addr = a; io_wdata = d;
    #1;
  endtask

  task automatic idle();
    bus(0, 0, 10'h000, 16'h0);
  endtask

  task automatic test_reset();
    reset = 1;
    bus(1, 1, 10'h060, 16'hFFFF);
    cyc(); cyc();
    reset = 0;
    idle();
    checks++; if (led_out !== 24'h0) begin errors++; $display("FAIL reset_led got %h want 000000", led_out); end
    checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", timer_irq); end
    checks++; if (io_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", io_err); end
    checks++; if (io_rdata !== 16'h0) begin errors++; $display("FAIL reset_rdata got %h want 0000", io_rdata); end
    bus(1, 0, 10'h024, 16'h0);
    checks++; if (io_rdata !== 16'h0) begin errors++; $display("FAIL reset_count got %h want 0000", io_rdata); end
  endtask

  task automatic test_led();
    bus(0, 1, 10'h060, 16'hA5A5); cyc();
    bus(0, 1, 10'h062, 16'h01FF); cyc();
    bus(1, 0, 10'h062, 16'h0);
    checks++; if (led_out !== 24'hFFA5A5) begin errors++; $display("FAIL led_out got %h want FFA5A5", led_out); end
    checks++; if (io_rdata !== 16'h00FF) begin errors++; $display("FAIL ledhi_read got %h want 00FF", io_rdata); end
    bus(1, 0, 10'h060, 16'h0);
    checks++; if (io_rdata !== 16'hA5A5) begin errors++; $display("FAIL ledlo_read got %h want A5A5", io_rdata); end
    bus(1, 1, 10'h060, 16'h1234);
    checks++; if (io_rdata !== 16'h0) begin errors++; $display("FAIL rdwr_rdata got %h want 0000", io_rdata); end
    cyc();
    checks++; if (led_out !== 24'hFF1234 || io_err !== 1'b0) begin errors++; $display("FAIL rdwr_write led %h err %b want FF1234 0", led_out, io_err); end
    bus(0, 1, 10'h060, 16'hA5A5); cyc();
    idle();
  endtask

  task automatic test_switch();
    switch_in = 24'h123456;
    for (int k = 0; k <= SYNC + 1; k++) begin
      bus(1, 0, 10'h070, 16'h0);
      checks++;
      if (io_rdata !== ((k >= SYNC) ? 16'h3456 : 16'h0000)) begin
        errors++; $display("FAIL swlo_cycle%0d got %h want %h", k, io_rdata, (k >= SYNC) ? 16'h3456 : 16'h0000);
      end
      bus(1, 0, 10'h072, 16'h0);
      checks++;
      if (io_rdata !== ((k >= SYNC) ? 16'h0012 : 16'h0000)) begin
        errors++; $display("FAIL swhi_cycle%0d got %h want %h", k, io_rdata, (k >= SYNC) ? 16'h0012 : 16'h0000);
      end
      bus(0, 1, 10'h070, 16'hFFFF);
      cyc();
    end
    idle();
  endtask

  task automatic test_timer_oneshot();
    bus(0, 1, 10'h024, 16'd3); cyc();
    bus(0, 1, 10'h020, 16'h0001); cyc();
    for (int n = 1; n <= 12; n++) begin
      bus(1, 0, 10'h024, 16'h0);
      checks++;
      if (io_rdata !== 16'(3 - (n - 1) / 4)) begin
        errors++; $display("FAIL oneshot_count_edge%0d got %0d want %0d", n, io_rdata, 3 - (n - 1) / 4);
      end
      checks++;
      if (timer_irq !== 1'b0) begin errors++; $display("FAIL oneshot_early_irq edge%0d got 1 want 0", n); end
      cyc();
    end
    bus(1, 0, 10'h024, 16'h0);
    checks++; if (io_rdata !== 16'h0) begin errors++; $display("FAIL oneshot_final_count got %h want 0000", io_rdata); end
    checks++; if (timer_irq !== 1'b1) begin errors++; $display("FAIL oneshot_irq got %b want 1", timer_irq); end
    bus(1, 0, 10'h020, 16'h0);
    checks++; if (io_rdata !== 16'h0001) begin errors++; $display("FAIL oneshot_status got %h want 0001", io_rdata); end
    cyc();
    idle();
    checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL oneshot_clear got %b want 0", timer_irq); end
    repeat (8) cyc();
    bus(1, 0, 10'h024, 16'h0);
    checks++; if (io_rdata !== 16'h0 || timer_irq !== 1'b0) begin errors++; $display("FAIL oneshot_stopped count %h irq %b want 0000 0", io_rdata, timer_irq); end
    idle();
  endtask

  task automatic test_reload();
    bus(0, 1, 10'h024, 16'd2); cyc();
    bus(0, 1, 10'h020, 16'h0003); cyc();
    idle();
    repeat (7) cyc();
    checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL reload_early got %b want 0", timer_irq); end
    cyc();
    checks++; if (timer_irq !== 1'b1) begin errors++; $display("FAIL reload_irq got %b want 1", timer_irq); end
    bus(1, 0, 10'h024, 16'h0);
    checks++; if (io_rdata !== 16'd2) begin errors++; $display("FAIL reload_count got %0d want 2", io_rdata); end
    bus(1, 0, 10'h020, 16'h0);
    checks++; if (io_rdata !== 16'h0007) begin errors++; $display("FAIL reload_status1 got %h want 0007", io_rdata); end
    cyc();
    idle();
    checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL reload_clear got %b want 0", timer_irq); end
    repeat (6) cyc();
    bus(1, 0, 10'h020, 16'h0);
    checks++; if (io_rdata !== 16'h0006) begin errors++; $display("FAIL reload_status2 got %h want 0006", io_rdata); end
    cyc();
    idle();
    checks++; if (timer_irq !== 1'b1) begin errors++; $display("FAIL reload_done_wins got %b want 1", timer_irq); end
    bus(0, 1, 10'h020, 16'h0000); cyc();
    idle();
  endtask

  task automatic test_unmapped();
    bus(1, 0, 10'h040, 16'h0);
    checks++; if (io_rdata !== 16'h0) begin errors++; $display("FAIL unmapped_rdata got %h want 0000", io_rdata); end
    cyc();
    idle();
    checks++; if (io_err !== 1'b1) begin errors++; $display("FAIL unmapped_rd_err got %b want 1", io_err); end
    cyc();
    checks++; if (io_err !== 1'b0) begin errors++; $display("FAIL unmapped_rd_pulse got %b want 0", io_err); end
    bus(0, 1, 10'h3FE, 16'hFFFF);
    cyc();
    idle();
    checks++; if (io_err !== 1'b1) begin errors++; $display("FAIL unmapped_wr_err got %b want 1", io_err); end
    checks++; if (led_out !== 24'hFFA5A5) begin errors++; $display("FAIL unmapped_led got %h want FFA5A5", led_out); end
    cyc();
    checks++; if (io_err !== 1'b0) begin errors++; $display("FAIL unmapped_wr_pulse got %b want 0", io_err); end
  endtask

  task automatic test_reset_midcount();
    bus(0, 1, 10'h060, 16'hFFFF); cyc();
    bus(0, 1, 10'h024, 16'd2); cyc();
    bus(0, 1, 10'h020, 16'h0001); cyc();
    reset = 1;
    bus(0, 1, 10'h060, 16'h1234);
    cyc();
    reset = 0;
    idle();
    checks++; if (led_out !== 24'h0) begin errors++; $display("FAIL midreset_led got %h want 000000", led_out); end
    checks++; if (timer_irq !== 1'b0 || io_err !== 1'b0) begin errors++; $display("FAIL midreset_flags irq %b err %b want 0 0", timer_irq, io_err); end
    bus(1, 0, 10'h024, 16'h0);
    checks++; if (io_rdata !== 16'h0) begin errors++; $display("FAIL midreset_count got %h want 0000", io_rdata); end
    bus(1, 0, 10'h020, 16'h0);
    checks++; if (io_rdata !== 16'h0) begin errors++; $display("FAIL midreset_status got %h want 0000", io_rdata); end
    bus(1, 0, 10'h070, 16'h0);
    checks++; if (io_rdata !== 16'h0) begin errors++; $display("FAIL midreset_sw got %h want 0000", io_rdata); end
    idle();
    repeat (8) cyc();
    bus(1, 0, 10'h024, 16'h0);
    checks++; if (io_rdata !== 16'h0) begin errors++; $display("FAIL midreset_nocount got %h want 0000", io_rdata); end
    idle();
  endtask

  task automatic test_random();
    logic [9:0] addrs [8];
    logic [9:0] a;
    int r;
    addrs = '{10'h060, 10'h062, 10'h070, 10'h072, 10'h020, 10'h024, 10'h040, 10'h3FE};
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) switch_in = 24'($urandom);
      reset = ($urandom_range(0, 149) == 0);
      a = addrs[$urandom_range(0, 7)];
      r = $urandom_range(0, 9);
      if (r <= 3) bus(1, 0, a, 16'h0);
      else if (r <= 7) begin
        if (a == 10'h024) bus(0, 1, a, 16'($urandom_range(0, 4)));
        else if (a == 10'h020) bus(0, 1, a, 16'($urandom_range(0, 3)) | (($urandom_range(0, 3) != 0) ? 16'h1 : 16'h0));
        else bus(0, 1, a, 16'($urandom));
      end
      else if (r == 8) bus(1, 1, a, 16'($urandom));
      else idle();
      checks++;
      if (io_rdata !== exp_rdata()) begin
        errors++; $display("FAIL rand_rdata it%0d addr %h got %h want %h", i, io_addr, io_rdata, exp_rdata());
      end
      cyc();
      checks++;
      if (led_out !== {m_ledhi[7:0], m_ledlo[15:0]} || timer_irq !== m_done || io_err !== m_err) begin
        errors++;
        $display("FAIL rand_state it%0d led %h irq %b err %b want %h %b %b", i, led_out, timer_irq, io_err,
                 {m_ledhi[7:0], m_ledlo[15:0]}, m_done, m_err);
      end
    end
    reset = 0;
    idle();
  endtask

  initial begin
    test_reset();
    test_led();
    test_switch();
    test_timer_oneshot();
    test_reload();
    test_unmapped();
    test_reset_midcount();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
